// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, holds it for a
// fixed number of cycles, then performs the access on a local word array
// and presents the result until the requester takes it.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a request; req_ready high
// WAIT  | request captured, latency counter running down
// RESP  | access committed, response held until rsp_ready
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2    // legal range 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // WAIT always lasts LATENCY cycles, so the counter starts at LATENCY-1
    // and the commit happens on the edge where it is already zero.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  state;
    logic [3:0]  lat_cnt;

    logic        cap_write;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;

    logic [31:0] mem [DEPTH];

    logic [29:0]   cap_idx;
    logic [AW-1:0] mem_idx;
    logic          acc_err;
    logic          commit;
    logic          accept;
    logic [31:0]   old_word;
    logic [31:0]   new_word;

    // Requests are only taken in IDLE and never while reset is held.
    always_comb begin
        req_ready = (state == ST_IDLE) && !reset;
        accept    = req_valid && req_ready;
    end

    // Sequencing: IDLE -> WAIT -> RESP -> IDLE, counter paces the WAIT phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            lat_cnt <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state   <= ST_WAIT;
                        lat_cnt <= CNT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        state <= ST_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Capture the request fields on acceptance; they stay put until the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_write <= 1'b0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            cap_be    <= 4'd0;
        end else if (accept) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
        end
    end

    // Address decode and the merged store word, from the captured request.
    // Loads ignore byte enables, so the merged word equals the stored word.
    always_comb begin
        cap_idx  = cap_addr[31:2];
        acc_err  = (cap_addr[1:0] != 2'b00) || (cap_idx >= 30'(DEPTH));
        mem_idx  = cap_idx[AW-1:0];
        old_word = mem[mem_idx];
        new_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (cap_write && cap_be[i]) begin
                new_word[8*i +: 8] = cap_wdata[8*i +: 8];
            end
        end
        commit = (state == ST_WAIT) && (lat_cnt == 4'd0);
    end

    // Word array write; reset forces IDLE, so a discarded request never commits.
    always_ff @(posedge clk) begin
        if (commit && cap_write && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (cap_be[i]) begin
                    mem[mem_idx][8*i +: 8] <= cap_wdata[8*i +: 8];
                end
            end
        end
    end

    // Response registers: loaded at commit, valid cleared on the handshake,
    // data and error left holding their last values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (commit) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= acc_err ? 32'd0 : new_word;
            rsp_err   <= acc_err;
        end else if ((state == ST_RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
